// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, FSM state codes,
// ALU function codes, PC source selects and the decoded instruction classes.
package ctrl_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;

   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b101
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_J,
      CLS_HALT,
      CLS_ILLEGAL
   } instrClass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder: maps the latched opcode to an
// instruction class plus the ALU function, immediate-operand and rd-select bits.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] opCode,
   output instrClass_t     instrClass,
   output logic [2:0]      aluOp,
   output logic            aluSrcB,
   output logic            regDst
);

   always_comb begin
      instrClass = CLS_ILLEGAL;
      aluOp      = ALU_ADD;
      aluSrcB    = 1'b0;
      regDst     = 1'b0;
      case (opCode)
         OP_W'(OP_ADD):  begin instrClass = CLS_ALU;  regDst = 1'b1; end
         OP_W'(OP_SUB):  begin instrClass = CLS_ALU;  regDst = 1'b1; aluOp = ALU_SUB; end
         OP_W'(OP_ADDI): begin instrClass = CLS_ALU;  aluSrcB = 1'b1; end
         OP_W'(OP_OR):   begin instrClass = CLS_ALU;  regDst = 1'b1; aluOp = ALU_OR; end
         OP_W'(OP_AND):  begin instrClass = CLS_ALU;  regDst = 1'b1; aluOp = ALU_AND; end
         OP_W'(OP_ORI):  begin instrClass = CLS_ALU;  aluSrcB = 1'b1; aluOp = ALU_OR; end
         OP_W'(OP_SW):   begin instrClass = CLS_SW;   aluSrcB = 1'b1; end
         OP_W'(OP_LW):   begin instrClass = CLS_LW;   aluSrcB = 1'b1; end
         OP_W'(OP_BEQ):  begin instrClass = CLS_BEQ;  aluOp = ALU_SUB; end
         OP_W'(OP_J):    instrClass = CLS_J;
         OP_W'(OP_HALT): instrClass = CLS_HALT;
         default:        instrClass = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EXE/MEM/WB/HALT) with combinational outputs.
// Define INSTR_COUNT_EN to add the 32-bit retired-instruction counter InstrCount.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [OP_W-1:0] OpCode,
   input  logic            zero,
   output logic            PCWre,
   output logic            IRWre,
   output logic            ALUSrcB,
   output logic            RegWre,
   output logic            RegDst,
   output logic            DBDataSrc,
   output logic            MemWR,
   output logic            Halted,
   output logic [2:0]      ALUOp,
   output logic [1:0]      PCSrc,
`ifdef INSTR_COUNT_EN
   output logic [31:0]     InstrCount,
`endif
   output logic [2:0]      State
);

   state_t          state;
   logic [OP_W-1:0] opReg;
   instrClass_t     instrClass;
   logic [2:0]      decAluOp;
   logic            decAluSrcB;
   logic            decRegDst;

   ctrl_decode #(.OP_W(OP_W)) uDecode (
      .opCode     (opReg),
      .instrClass (instrClass),
      .aluOp      (decAluOp),
      .aluSrcB    (decAluSrcB),
      .regDst     (decRegDst)
   );

   // Opcode is captured once on leaving IF so later OpCode changes cannot disturb decode
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IF;
         opReg <= '0;
      end else begin
         case (state)
            S_IF: begin
               opReg <= OpCode;
               state <= S_ID;
            end
            S_ID: begin
               case (instrClass)
                  CLS_J, CLS_ILLEGAL: state <= S_IF;
                  CLS_HALT:           state <= S_HALT;
                  default:            state <= S_EXE;
               endcase
            end
            S_EXE: begin
               case (instrClass)
                  CLS_BEQ:        state <= S_IF;
                  CLS_LW, CLS_SW: state <= S_MEM;
                  default:        state <= S_WB;
               endcase
            end
            S_MEM:   state <= (instrClass == CLS_LW) ? S_WB : S_IF;
            S_WB:    state <= S_IF;
            S_HALT:  state <= S_HALT;
            default: state <= S_IF;
         endcase
      end
   end

   // Everything is gated by RST so an asserted reset silences all enables at once
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      ALUSrcB   = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 1'b0;
      DBDataSrc = 1'b0;
      MemWR     = 1'b0;
      Halted    = 1'b0;
      ALUOp     = 3'b000;
      PCSrc     = PCSRC_SEQ;
      State     = 3'b000;
      if (RST) begin
         State = state;
         ALUOp = decAluOp;
         case (state)
            S_IF: IRWre = 1'b1;
            S_ID: begin
               if (instrClass == CLS_J) begin
                  PCWre = 1'b1;
                  PCSrc = PCSRC_JUMP;
               end else if (instrClass == CLS_ILLEGAL) begin
                  PCWre = 1'b1;
               end
            end
            S_EXE: begin
               ALUSrcB = decAluSrcB;
               if (instrClass == CLS_BEQ) begin
                  PCWre = 1'b1;
                  if (zero) PCSrc = PCSRC_BRANCH;
               end
            end
            S_MEM: begin
               if (instrClass == CLS_SW) begin
                  MemWR = 1'b1;
                  PCWre = 1'b1;
               end
            end
            S_WB: begin
               RegWre    = 1'b1;
               PCWre     = 1'b1;
               RegDst    = decRegDst;
               DBDataSrc = (instrClass == CLS_LW);
            end
            S_HALT:  Halted = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef INSTR_COUNT_EN
   logic [31:0] instrCount;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) instrCount <= '0;
      else if (PCWre) instrCount <= instrCount + 32'd1;
   end

   assign InstrCount = instrCount;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; outputs are sampled on the
// falling edge and compared against hand-computed per-cycle control vectors.
module tb_multicycle_ctrl;

   logic       CLK;
   logic       RST;
   logic [5:0] OpCode;
   logic       zero;
   logic       PCWre, IRWre, ALUSrcB, RegWre, RegDst, DBDataSrc, MemWR, Halted;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;
   logic [2:0] State;
`ifdef INSTR_COUNT_EN
   logic [31:0] InstrCount;
`endif

   int checkCount = 0;
   int passCount  = 0;

   multicycle_ctrl #(.OP_W(6)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .OpCode     (OpCode),
      .zero       (zero),
      .PCWre      (PCWre),
      .IRWre      (IRWre),
      .ALUSrcB    (ALUSrcB),
      .RegWre     (RegWre),
      .RegDst     (RegDst),
      .DBDataSrc  (DBDataSrc),
      .MemWR      (MemWR),
      .Halted     (Halted),
      .ALUOp      (ALUOp),
      .PCSrc      (PCSrc),
`ifdef INSTR_COUNT_EN
      .InstrCount (InstrCount),
`endif
      .State      (State)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] outs();
      return {State, PCWre, IRWre, ALUSrcB, RegWre, RegDst, DBDataSrc, MemWR, Halted, ALUOp, PCSrc};
   endfunction

   // Expected control vector in the same packing as outs()
   function automatic logic [15:0] e(input int st, input int pcw, input int irw, input int srcb,
                                     input int rw, input int dst, input int db, input int mw,
                                     input int h, input int alu, input int pcs);
      return {st[2:0], pcw[0], irw[0], srcb[0], rw[0], dst[0], db[0], mw[0], h[0], alu[2:0], pcs[1:0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [5:0] op, input logic z);
      OpCode = op;
      zero   = z;
   endtask

   task automatic cyc(input string tag, input logic [15:0] expected);
      checkOutput(tag, {16'h0, outs()}, {16'h0, expected});
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b0;
      applyStimulus(6'b000000, 1'b0);
      repeat (2) @(negedge CLK);
      checkOutput("rstOuts", {16'h0, outs()}, 32'h0);
`ifdef INSTR_COUNT_EN
      checkOutput("rstCount", InstrCount, 32'h0);
`endif

      // ADD: IF, ID, EXE, WB; OpCode scrambled after IF must not matter
      RST = 1'b1;
      #1;
      cyc("addIF", e(0,0,1,0,0,0,0,0,0,0,0));
      applyStimulus(6'b111111, 1'b0);
      cyc("addID", e(1,0,0,0,0,0,0,0,0,0,0));
      cyc("addEXE", e(2,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(6'b110100, 1'b1);
      cyc("addWB", e(4,1,0,0,1,1,0,0,0,0,0));

      // BEQ taken
      cyc("beqIF", e(0,0,1,0,0,0,0,0,0,0,0));
      cyc("beqID", e(1,0,0,0,0,0,0,0,0,1,0));
      applyStimulus(6'b110100, 1'b0);
      #1;
      checkOutput("beqEXEz0", {16'h0, outs()}, {16'h0, e(2,1,0,0,0,0,0,0,0,1,0)});
      zero = 1'b1;
      #1;
      cyc("beqEXEz1", e(2,1,0,0,0,0,0,0,0,1,1));

      // BEQ not taken
      applyStimulus(6'b110100, 1'b0);
      cyc("beqNtIF", e(0,0,1,0,0,0,0,0,0,1,0));
      cyc("beqNtID", e(1,0,0,0,0,0,0,0,0,1,0));
      applyStimulus(6'b110001, 1'b0);
      cyc("beqNtEXE", e(2,1,0,0,0,0,0,0,0,1,0));

      // LW then SW
      cyc("lwIF", e(0,0,1,0,0,0,0,0,0,1,0));
      cyc("lwID", e(1,0,0,0,0,0,0,0,0,0,0));
      cyc("lwEXE", e(2,0,0,1,0,0,0,0,0,0,0));
      cyc("lwMEM", e(3,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(6'b110000, 1'b0);
      cyc("lwWB", e(4,1,0,0,1,0,1,0,0,0,0));
      cyc("swIF", e(0,0,1,0,0,0,0,0,0,0,0));
      cyc("swID", e(1,0,0,0,0,0,0,0,0,0,0));
      cyc("swEXE", e(2,0,0,1,0,0,0,0,0,0,0));
      applyStimulus(6'b111000, 1'b0);
      cyc("swMEM", e(3,1,0,0,0,0,0,1,0,0,0));

      // J retires in ID, then an illegal opcode does the same without jumping
      cyc("jIF", e(0,0,1,0,0,0,0,0,0,0,0));
`ifdef INSTR_COUNT_EN
      force dut.instrCount = 32'hFFFFFFFF;
      #1;
      release dut.instrCount;
`endif
      applyStimulus(6'b000011, 1'b0);
`ifdef INSTR_COUNT_EN
      checkOutput("cntPreJ", InstrCount, 32'hFFFFFFFF);
`endif
      cyc("jID", e(1,1,0,0,0,0,0,0,0,0,2));
`ifdef INSTR_COUNT_EN
      checkOutput("cntWrap", InstrCount, 32'h0);
`endif
      cyc("illIF", e(0,0,1,0,0,0,0,0,0,0,0));
      applyStimulus(6'b010010, 1'b0);
      cyc("illID", e(1,1,0,0,0,0,0,0,0,0,0));

      // ORI aborted by reset in WB
      cyc("oriIF", e(0,0,1,0,0,0,0,0,0,0,0));
      cyc("oriID", e(1,0,0,0,0,0,0,0,0,3,0));
      cyc("oriEXE", e(2,0,0,1,0,0,0,0,0,3,0));
      checkOutput("oriWB", {16'h0, outs()}, {16'h0, e(4,1,0,0,1,0,0,0,0,3,0)});
      RST = 1'b0;
      #1;
      checkOutput("oriAbort", {16'h0, outs()}, 32'h0);
      @(negedge CLK);
      checkOutput("oriHeld", {16'h0, outs()}, 32'h0);
      applyStimulus(6'b111111, 1'b0);
      RST = 1'b1;
      #1;
      cyc("restartIF", e(0,0,1,0,0,0,0,0,0,0,0));

      // HALT sticks until reset
      cyc("haltID", e(1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(6'b000000, 1'b0);
      for (int i = 0; i < 4; i++) cyc("haltHold", e(5,0,0,0,0,0,0,0,1,0,0));
      RST = 1'b0;
      #1;
      checkOutput("haltRst", {16'h0, outs()}, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      cyc("haltExitIF", e(0,0,1,0,0,0,0,0,0,0,0));
      cyc("haltExitID", e(1,0,0,0,0,0,0,0,0,0,0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
